// File: rtl/prot_pkg.sv
// Definitions shared by the protocol-trigger SPI receiver and the SPI transmitter:
// frame lengths, SCLK edge encoding and the transmitter state type.
package prot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FRONT,
        ST_LOW,
        ST_HIGH,
        ST_BACK
    } spi_tx_state_t;

    localparam int LEN8  = 8;
    localparam int LEN16 = 16;

    localparam logic EDG_RISE = 1'b1;
    localparam logic EDG_FALL = 1'b0;

    function automatic logic [4:0] frame_bits(input logic len8);
        return len8 ? 5'(LEN8) : 5'(LEN16);
    endfunction

endpackage

// File: rtl/spi_tx_clkgen.sv
// Half-period timer and SCLK register for the SPI transmitter; the rise/fall
// pulses flag the system clock edge on which SCLK will change.
module spi_tx_clkgen #(
    parameter int SCLK_DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    input  logic i_en,
    input  logic i_hold,
    output logic o_sclk,
    output logic o_tc,
    output logic o_sclk_rise,
    output logic o_sclk_fall
);
    localparam int HALF = SCLK_DIV / 2;
    localparam int CW   = $clog2(HALF + 1);

    logic [CW-1:0] r_cnt;
    logic          r_sclk;
    logic          w_tc;
    logic          w_toggle;

    assign w_tc     = i_en && (r_cnt == '0);
    assign w_toggle = w_tc && !i_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_sclk <= 1'b1;
        end else begin
            if (i_start || w_tc) begin
                r_cnt <= CW'(HALF - 1);
            end else if (i_en) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (i_start) begin
                r_sclk <= 1'b1;
            end else if (w_toggle) begin
                r_sclk <= ~r_sclk;
            end
        end
    end

    assign o_sclk      = r_sclk;
    assign o_tc        = w_tc;
    assign o_sclk_rise = w_toggle && !r_sclk;
    assign o_sclk_fall = w_toggle && r_sclk;

endmodule

// File: rtl/spi_tx.sv
// SPI master transmitter: frames 8/16-bit words on SS_n/SCLK/MOSI, MSB first,
// and captures MISO on the opposite SCLK edge to the one MOSI moves on.
//
// state | meaning
// IDLE  | waiting for wrt, SS_n high, SCLK high
// FRONT | SS_n low, SCLK high, MSB presented for HALF clocks
// LOW   | SCLK low half period
// HIGH  | SCLK high half period; after the Nth one the frame ends
// BACK  | SCLK high trailer of HALF clocks before SS_n is released
module spi_tx #(
    parameter int SCLK_DIV = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt,
    input  logic [15:0] cmd,
    input  logic        len8_16,
    input  logic        edg,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic        busy,
    output logic        done,
    output logic [15:0] rd_data
);
    import prot_pkg::*;

    spi_tx_state_t r_state, w_state_nxt;

    logic        r_len8;
    logic        r_edg;
    logic [15:0] r_tx;
    logic [15:0] r_rx;
    logic [4:0]  r_bits_left;
    logic        r_ss_n;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_rd_data;

    logic w_start, w_hold, w_en, w_tc, w_sclk, w_rise, w_fall;
    logic w_adv, w_cap, w_end;

    spi_tx_clkgen #(.SCLK_DIV(SCLK_DIV)) u_clkgen (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (w_start),
        .i_en        (w_en),
        .i_hold      (w_hold),
        .o_sclk      (w_sclk),
        .o_tc        (w_tc),
        .o_sclk_rise (w_rise),
        .o_sclk_fall (w_fall)
    );

    assign w_en = (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_hold      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_hold = 1'b1;
                if (wrt) begin
                    w_state_nxt = ST_FRONT;
                    w_start     = 1'b1;
                end
            end
            ST_FRONT: if (w_tc) w_state_nxt = ST_LOW;
            ST_LOW:   if (w_tc) w_state_nxt = ST_HIGH;
            ST_HIGH: begin
                w_hold = (r_bits_left == 5'd0);
                if (w_tc) w_state_nxt = w_hold ? ST_BACK : ST_LOW;
            end
            ST_BACK: begin
                w_hold = 1'b1;
                if (w_tc) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // The first fall (out of FRONT) and the last rise never move MOSI,
    // so each bit is held a full SCLK period around its sampling edge.
    assign w_adv = (r_edg == EDG_RISE) ? (w_fall && (r_state == ST_HIGH))
                                       : (w_rise && (r_bits_left != 5'd1));
    assign w_cap = (r_edg == EDG_FALL) ? w_fall : w_rise;
    assign w_end = (r_state == ST_BACK) && w_tc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len8      <= 1'b0;
            r_edg       <= 1'b0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_bits_left <= '0;
            r_ss_n      <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rd_data   <= '0;
        end else begin
            if (w_start) begin
                r_len8      <= len8_16;
                r_edg       <= edg;
                r_tx        <= len8_16 ? {cmd[7:0], 8'h00} : cmd;
                r_rx        <= '0;
                r_bits_left <= frame_bits(len8_16);
            end else begin
                if (w_rise) r_bits_left <= r_bits_left - 5'd1;
                if (w_adv)  r_tx <= {r_tx[14:0], 1'b0};
                if (w_cap)  r_rx <= {r_rx[14:0], MISO};
            end
            r_ss_n <= (w_state_nxt == ST_IDLE);
            r_busy <= (w_state_nxt != ST_IDLE);
            r_done <= w_end;
            if (w_end) begin
                r_rd_data <= r_len8 ? {8'h00, r_rx[7:0]} : r_rx;
            end
        end
    end

    assign SS_n    = r_ss_n;
    assign SCLK    = w_sclk;
    assign MOSI    = r_tx[15];
    assign busy    = r_busy;
    assign done    = r_done;
    assign rd_data = r_rd_data;

endmodule

// File: tb/tb_spi_tx.sv
// Directed self-checking bench for spi_tx with SCLK_DIV=16.
module tb_spi_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wrt = 1'b0;
    logic [15:0] cmd = '0;
    logic        len8_16 = 1'b0;
    logic        edg = 1'b0;
    logic        miso;
    logic        SS_n, SCLK, MOSI, busy, done;
    logic [15:0] rd_data;

    logic loopback = 1'b0;
    logic miso_drv = 1'b0;
    assign miso = loopback ? MOSI : miso_drv;

    int checks = 0;
    int failures = 0;

    // results of the most recent run_frame
    int          fr_len, rise_cnt, fall_cnt, done_cnt, post_active, busy_bad;
    logic [15:0] rise_bits, fall_bits, rd_at_done;
    logic        ss_first, busy_first, done_ss, done_busy;

    spi_tx #(.SCLK_DIV(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt     (wrt),
        .cmd     (cmd),
        .len8_16 (len8_16),
        .edg     (edg),
        .MISO    (miso),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .busy    (busy),
        .done    (done),
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    // Starts one frame, scrambles the inputs once it is accepted, and records what a
    // receiver would see; optional second wrt pulse at cycle lock_at.
    task automatic run_frame(input logic [15:0] c, input logic l8, input logic e,
                             input int lock_at, input logic [15:0] c_lock);
        logic prev_sclk, prev_mosi, seen_done;
        int post;
        @(posedge clk); #1;
        cmd = c; len8_16 = l8; edg = e; wrt = 1'b1;
        @(posedge clk); #1;
        wrt = 1'b0; cmd = ~c; len8_16 = ~l8; edg = ~e;
        prev_sclk = SCLK; prev_mosi = MOSI;
        fr_len = 0; rise_cnt = 0; fall_cnt = 0; done_cnt = 0; post_active = 0; busy_bad = 0;
        rise_bits = '0; fall_bits = '0; rd_at_done = 'x;
        ss_first = 1'bx; busy_first = 1'bx; done_ss = 1'bx; done_busy = 1'bx;
        seen_done = 1'b0; post = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(negedge clk);
            if (cyc == lock_at) begin
                wrt = 1'b1; cmd = c_lock;
            end else if (cyc == lock_at + 1) begin
                wrt = 1'b0;
            end
            if (cyc == 0) begin
                ss_first = SS_n; busy_first = busy;
            end
            if (SS_n === 1'b0) fr_len++;
            if (busy !== ~SS_n) busy_bad++;
            if (SCLK === 1'b1 && prev_sclk === 1'b0) begin
                rise_cnt++; rise_bits = {rise_bits[14:0], prev_mosi};
            end
            if (SCLK === 1'b0 && prev_sclk === 1'b1) begin
                fall_cnt++; fall_bits = {fall_bits[14:0], prev_mosi};
            end
            if (seen_done) begin
                if (SS_n !== 1'b1 || SCLK !== 1'b1 || busy !== 1'b0) post_active++;
                post--;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (!seen_done) begin
                    seen_done = 1'b1; post = 20;
                    done_ss = SS_n; done_busy = busy; rd_at_done = rd_data;
                end
            end
            prev_sclk = SCLK; prev_mosi = MOSI;
            if (seen_done && post == 0) break;
        end
        wrt = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (SS_n !== 1'b1) begin failures++; $display("FAIL reset_ss_n got=%b exp=1", SS_n); end
        checks++; if (SCLK !== 1'b1) begin failures++; $display("FAIL reset_sclk got=%b exp=1", SCLK); end
        checks++; if (MOSI !== 1'b0) begin failures++; $display("FAIL reset_mosi got=%b exp=0", MOSI); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
        checks++; if (rd_data !== 16'h0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0000", rd_data); end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_byte_send();
        loopback = 1'b0; miso_drv = 1'b1;
        run_frame(16'h00A5, 1'b1, 1'b1, -1, 16'h0);
        checks++; if (ss_first !== 1'b0 || busy_first !== 1'b1) begin failures++; $display("FAIL byte_start ss/busy got=%b/%b exp=0/1", ss_first, busy_first); end
        checks++; if (rise_cnt != 8) begin failures++; $display("FAIL byte_rises got=%0d exp=8", rise_cnt); end
        checks++; if (fall_cnt != 8) begin failures++; $display("FAIL byte_falls got=%0d exp=8", fall_cnt); end
        checks++; if (rise_bits !== 16'h00A5) begin failures++; $display("FAIL byte_bits got=%h exp=00a5", rise_bits); end
        checks++; if (fr_len != 144) begin failures++; $display("FAIL byte_len got=%0d exp=144", fr_len); end
        checks++; if (done_cnt != 1 || done_ss !== 1'b1 || done_busy !== 1'b0) begin failures++; $display("FAIL byte_done cnt=%0d ss=%b busy=%b exp=1/1/0", done_cnt, done_ss, done_busy); end
        checks++; if (rd_at_done !== 16'h00FF) begin failures++; $display("FAIL byte_rd_data got=%h exp=00ff", rd_at_done); end
        checks++; if (busy_bad != 0 || post_active != 0) begin failures++; $display("FAIL byte_busy_idle bad=%0d post=%0d exp=0/0", busy_bad, post_active); end
    endtask

    task automatic test_word_loopback();
        loopback = 1'b1;
        run_frame(16'hC3E1, 1'b0, 1'b0, -1, 16'h0);
        checks++; if (fall_cnt != 16 || rise_cnt != 16) begin failures++; $display("FAIL word_edges falls=%0d rises=%0d exp=16/16", fall_cnt, rise_cnt); end
        checks++; if (fall_bits !== 16'hC3E1) begin failures++; $display("FAIL word_bits got=%h exp=c3e1", fall_bits); end
        checks++; if (rd_at_done !== 16'hC3E1) begin failures++; $display("FAIL word_rd_data got=%h exp=c3e1", rd_at_done); end
        checks++; if (fr_len != 272) begin failures++; $display("FAIL word_len got=%0d exp=272", fr_len); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL word_done got=%0d exp=1", done_cnt); end
        loopback = 1'b0;
    endtask

    task automatic test_trigger_pairing();
        logic trig;
        miso_drv = 1'b0;
        run_frame(16'h1234, 1'b0, 1'b1, -1, 16'h0);
        trig = (rise_cnt == 16) && (rise_bits == 16'h1234);
        checks++; if (trig !== 1'b1) begin failures++; $display("FAIL trig_match got=%b exp=1 bits=%h", trig, rise_bits); end
        run_frame(16'h1235, 1'b0, 1'b1, -1, 16'h0);
        trig = (rise_cnt == 16) && (rise_bits == 16'h1234);
        checks++; if (trig !== 1'b0 || rise_bits !== 16'h1235) begin failures++; $display("FAIL trig_nomatch got=%b bits=%h exp=0/1235", trig, rise_bits); end
    endtask

    task automatic test_busy_lockout();
        miso_drv = 1'b1;
        run_frame(16'h0011, 1'b0, 1'b1, 40, 16'h00FF);
        checks++; if (rise_bits !== 16'h0011) begin failures++; $display("FAIL lock_bits got=%h exp=0011", rise_bits); end
        checks++; if (done_cnt != 1 || post_active != 0) begin failures++; $display("FAIL lock_done cnt=%0d post=%0d exp=1/0", done_cnt, post_active); end
        checks++; if (fr_len != 272) begin failures++; $display("FAIL lock_len got=%0d exp=272", fr_len); end
        checks++; if (rd_at_done !== 16'hFFFF) begin failures++; $display("FAIL lock_rd_data got=%h exp=ffff", rd_at_done); end
    endtask

    task automatic test_reset_midframe();
        int rises;
        logic prev;
        @(posedge clk); #1;
        cmd = 16'hFFFF; len8_16 = 1'b0; edg = 1'b1; wrt = 1'b1;
        @(posedge clk); #1;
        wrt = 1'b0;
        rises = 0; prev = SCLK;
        for (int cyc = 0; cyc < 1000 && rises < 5; cyc++) begin
            @(negedge clk);
            if (SCLK === 1'b1 && prev === 1'b0) rises++;
            prev = SCLK;
        end
        checks++; if (rises != 5 || SS_n !== 1'b0 || MOSI !== 1'b1) begin failures++; $display("FAIL rst_pre rises=%0d ss=%b mosi=%b exp=5/0/1", rises, SS_n, MOSI); end
        #2; rst_n = 1'b0; #1;
        checks++; if (SS_n !== 1'b1 || SCLK !== 1'b1) begin failures++; $display("FAIL rst_mid_ss_sclk got=%b%b exp=11", SS_n, SCLK); end
        checks++; if (MOSI !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_mid_mosi_busy got=%b%b exp=00", MOSI, busy); end
        checks++; if (rd_data !== 16'h0 || done !== 1'b0) begin failures++; $display("FAIL rst_mid_rd_done got=%h/%b exp=0000/0", rd_data, done); end
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        miso_drv = 1'b0;
        run_frame(16'h005A, 1'b1, 1'b1, -1, 16'h0);
        checks++; if (rise_bits !== 16'h005A || rise_cnt != 8) begin failures++; $display("FAIL rst_after_bits got=%h/%0d exp=005a/8", rise_bits, rise_cnt); end
        checks++; if (done_cnt != 1 || fr_len != 144) begin failures++; $display("FAIL rst_after_frame done=%0d len=%0d exp=1/144", done_cnt, fr_len); end
    endtask

    task automatic test_back_to_back();
        int frames, dones, len, gap, gap_bad, len_bad, gaps;
        logic prev_ss;
        frames = 0; dones = 0; len = 0; gap = 0; gap_bad = 0; len_bad = 0; gaps = 0;
        @(posedge clk); #1;
        cmd = 16'h00A5; len8_16 = 1'b1; edg = 1'b1; wrt = 1'b1;
        prev_ss = SS_n;
        for (int cyc = 0; cyc < 2000 && frames < 3; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
            if (SS_n === 1'b0) len++;
            else gap++;
            if (SS_n === 1'b0 && prev_ss === 1'b1) begin
                if (frames > 0) begin
                    gaps++;
                    if (gap != 1) gap_bad++;
                end
                gap = 0;
            end
            if (SS_n === 1'b1 && prev_ss === 1'b0) begin
                frames++;
                if (len != 144) len_bad++;
                len = 0; gap = 1;
            end
            prev_ss = SS_n;
        end
        wrt = 1'b0;
        checks++; if (frames != 3 || dones != 3) begin failures++; $display("FAIL b2b_frames frames=%0d dones=%0d exp=3/3", frames, dones); end
        checks++; if (gaps != 2 || gap_bad != 0) begin failures++; $display("FAIL b2b_gap gaps=%0d bad=%0d exp=2/0", gaps, gap_bad); end
        checks++; if (len_bad != 0) begin failures++; $display("FAIL b2b_len bad=%0d exp=0", len_bad); end
        repeat (300) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_byte_send();
        test_word_loopback();
        test_trigger_pairing();
        test_busy_lockout();
        test_reset_midframe();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
